// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the MULT/MULTU sequencer:
//   - state_t : controller states (IDLE, RUN, FIXUP, DONE)
//   - MULT_WIDTH / MULT_CNT_W : default operand and iteration-counter widths
//   - acc_t   : double-width product/accumulator type for the default width
// Optional feature macro used by the users of this package: MULT_EARLY_TERM_EN
// -----------------------------------------------------------------------------
package mult_pkg;

    localparam int MULT_WIDTH = 32;
    localparam int MULT_CNT_W = 6;    // 2**MULT_CNT_W must exceed MULT_WIDTH

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic [2*MULT_WIDTH-1:0] acc_t;

endpackage

// File: rtl/mult_datapath.sv
// -----------------------------------------------------------------------------
// mult_datapath
// Iterative shift-add multiplier datapath, magnitude based:
//   operands are converted to magnitudes on load, one multiplier bit is
//   consumed per step, and the sign is applied at the end by a fixup negate.
// Ports:
//   clk, reset          : core clock, asynchronous active-high reset
//   load                : capture |op_a|, |op_b| (or raw values) and sign, clear acc
//   step                : one shift-add iteration
//   fixup               : apply the product sign to the accumulator
//   signed_op           : 1 = two's complement operands, 0 = unsigned
//   op_a, op_b          : multiplicand / multiplier
//   count               : remaining-iteration counter owned by the controller
//   last_iter           : current step is the final one
//   result              : sign-corrected accumulator (valid during FIXUP)
// Optional feature: MULT_EARLY_TERM_EN -- when defined, a step whose remaining
//   multiplier bits are all zero finishes the product in one wide shift.
// -----------------------------------------------------------------------------
module mult_datapath
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int CNT_W = MULT_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic               fixup,
    input  logic               signed_op,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    input  logic [CNT_W-1:0]   count,
    output logic               last_iter,
    output logic [2*WIDTH-1:0] result
);

    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               neg_q, neg_d;

    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     partial;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH:0]   wide;
    logic [CNT_W:0]     shamt;
    logic               early;

    always_comb begin
        // The most negative value maps onto itself, which is its correct
        // magnitude once read as unsigned.
        a_abs = (signed_op && op_a[WIDTH-1]) ? (~op_a + 1'b1) : op_a;
        b_abs = (signed_op && op_b[WIDTH-1]) ? (~op_b + 1'b1) : op_b;

        // Carry out of the upper-half add is kept and shifted back in.
        partial = mplier_q[0] ? {1'b0, mcand_q} : '0;
        sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + partial;
        wide    = {sum, acc_q[WIDTH-1:0]};

`ifdef MULT_EARLY_TERM_EN
        // Nothing left to add after this bit: shift by every remaining
        // position at once so the result lands where the full loop would.
        early = (mplier_q[WIDTH-1:1] == '0);
        shamt = early ? ({1'b0, count} + 1'b1) : (CNT_W+1)'(1);
`else
        early = 1'b0;
        shamt = (CNT_W+1)'(1);
`endif

        last_iter = (count == '0) || early;
        result    = neg_q ? (~acc_q + 1'b1) : acc_q;

        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        neg_d    = neg_q;

        if (load) begin
            mcand_d  = a_abs;
            mplier_d = b_abs;
            neg_d    = signed_op & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            acc_d    = '0;
        end else if (step) begin
            acc_d    = (2*WIDTH)'(wide >> shamt);
            mplier_d = mplier_q >> 1;
        end else if (fixup) begin
            acc_d    = result;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
        end
    end

endmodule

// File: rtl/mult_sequencer.sv
// -----------------------------------------------------------------------------
// mult_sequencer
// Multi-cycle controller for MULT/MULTU. Owns the FSM, the iteration counter,
// the HI/LO result registers and the pipeline stall.
// Ports:
//   clk, reset    : core clock, asynchronous active-high reset
//   start         : multiply request from the decoder (accepted only in IDLE)
//   signed_op     : 1 = MULT, 0 = MULTU
//   op_a, op_b    : rs / rt operands, sampled on the accepted start edge
//   hilo_rd       : current instruction reads HI/LO
//   hi, lo        : product registers, updated on entry to DONE
//   busy          : any state other than IDLE
//   stall         : freeze fetch; busy and (new multiply or HI/LO read)
//   done          : one-cycle pulse in the cycle HI/LO become valid
// Optional feature: MULT_EARLY_TERM_EN (early exit once the multiplier's
//   remaining bits are zero; implemented in mult_datapath).
// Fixed latency without the feature: start at edge 0 -> done in cycle WIDTH+2.
// -----------------------------------------------------------------------------
module mult_sequencer
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int CNT_W = MULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             hilo_rd,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall,
    output logic             done
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               load, step, fixup;
    logic               last_iter;
    logic [2*WIDTH-1:0] result;

    mult_datapath #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_datapath (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .step      (step),
        .fixup     (fixup),
        .signed_op (signed_op),
        .op_a      (op_a),
        .op_b      (op_b),
        .count     (cnt_q),
        .last_iter (last_iter),
        .result    (result)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)     state_d = RUN;
            RUN:     if (last_iter) state_d = FIXUP;
            FIXUP:                  state_d = DONE;
            DONE:                   state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Outputs and datapath strobes decoded from the registered state
    always_comb begin
        busy  = (state_q != IDLE);
        done  = (state_q == DONE);
        load  = (state_q == IDLE) && start;
        step  = (state_q == RUN);
        fixup = (state_q == FIXUP);
        // In IDLE a start is accepted and a HI/LO read sees the settled
        // registers, so neither needs to hold the pipeline.
        stall = busy && (start || hilo_rd);
    end

    // Counter and HI/LO next values
    always_comb begin
        cnt_d = cnt_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        if (load) begin
            cnt_d = CNT_W'(WIDTH - 1);
        end else if (step) begin
            cnt_d = cnt_q - 1'b1;
        end
        // Loaded from the sign-corrected value so HI/LO are valid in DONE.
        if (fixup) begin
            hi_d = result[2*WIDTH-1:WIDTH];
            lo_d = result[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mult_sequencer
// Self-checking bench for mult_sequencer: directed corner cases plus random
// operations compared against an arithmetic reference (64-bit products and a
// latency rule). Honors MULT_EARLY_TERM_EN when compiled with it.
// -----------------------------------------------------------------------------
module tb_mult_sequencer;
    import mult_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         signed_op;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         hilo_rd;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         stall;
    logic         done;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] old_hi;
    logic [W-1:0] old_lo;

    always #5 clk = ~clk;

    mult_sequencer #(
        .WIDTH (W),
        .CNT_W (6)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .signed_op (signed_op),
        .op_a      (op_a),
        .op_b      (op_b),
        .hilo_rd   (hilo_rd),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .stall     (stall),
        .done      (done)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference product computed with plain 64-bit arithmetic.
    function automatic acc_t ref_product(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        longint          sa, sb;
        longint unsigned ua, ub;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return acc_t'(sa * sb);
        end
        ua = {32'b0, a};
        ub = {32'b0, b};
        return acc_t'(ua * ub);
    endfunction

    // Cycle (counted from the accepting edge) in which done is expected.
    function automatic int ref_latency(input logic [W-1:0] b, input logic s);
`ifdef MULT_EARLY_TERM_EN
        logic [W-1:0] m;
        m = (s && b[W-1]) ? (~b + 1'b1) : b;
        for (int i = W - 1; i >= 0; i--) begin
            if (m[i]) return 3 + i;
        end
        return 3;
`else
        if (s) return W + 2;
        return W + 2 + 0 * int'(b[0]);
`endif
    endfunction

    // Called mid-cycle while the DUT is IDLE. Issues one multiply and follows
    // it cycle by cycle up to the IDLE cycle after DONE.
    //   rd_at   : cycle (>0) from which hilo_rd is held high, 0 = never
    //   rd_idle : hilo_rd together with start in the accepting IDLE cycle
    //   hold    : keep start high during the op, presenting na/nb/ns next
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input int rd_at, input bit rd_idle, input bit hold,
                          input logic [W-1:0] na, input logic [W-1:0] nb, input logic ns);
        acc_t exp_p;
        int   exp_lat;
        int   got_lat;
        bit   exp_stall;

        exp_p     = ref_product(a, b, s);
        exp_lat   = ref_latency(b, s);
        got_lat   = 0;
        exp_stall = 1'b0;

        op_a = a; op_b = b; signed_op = s; start = 1'b1; hilo_rd = rd_idle;
        #1;
        check_eq("idle_busy",  64'(busy),  64'(0));
        check_eq("idle_stall", 64'(stall), 64'(0));
        check_eq("idle_hi",    64'(hi),    64'(old_hi));
        check_eq("idle_lo",    64'(lo),    64'(old_lo));

        @(posedge clk);
        #1;
        hilo_rd = 1'b0;
        if (hold) begin
            op_a = na; op_b = nb; signed_op = ns; start = 1'b1;
        end else begin
            start = 1'b0; op_a = $urandom; op_b = $urandom; signed_op = 1'($urandom);
        end

        for (int n = 1; n <= W + 8; n++) begin
            @(negedge clk);
            if (rd_at > 0 && n >= rd_at) hilo_rd = 1'b1;
            #1;
            exp_stall = hold || (rd_at > 0 && n >= rd_at);
            if (done) begin
                got_lat = n;
                break;
            end
            check_eq("run_busy",  64'(busy),  64'(1));
            check_eq("run_stall", 64'(stall), 64'(exp_stall));
            check_eq("run_hi",    64'(hi),    64'(old_hi));
            check_eq("run_lo",    64'(lo),    64'(old_lo));
        end

        check_eq("latency",    64'(got_lat), 64'(exp_lat));
        check_eq("done_hi",    64'(hi),      64'(exp_p[63:32]));
        check_eq("done_lo",    64'(lo),      64'(exp_p[31:0]));
        check_eq("done_busy",  64'(busy),    64'(1));
        check_eq("done_stall", 64'(stall),   64'(exp_stall));
        old_hi = exp_p[63:32];
        old_lo = exp_p[31:0];
        $display("mult a=%h b=%h signed=%0d hi=%h lo=%h latency=%0d", a, b, s, hi, lo, got_lat);

        @(negedge clk);
        #1;
        check_eq("post_busy",  64'(busy),  64'(0));
        check_eq("post_done",  64'(done),  64'(0));
        check_eq("post_stall", 64'(stall), 64'(0));
        check_eq("post_hi",    64'(hi),    64'(old_hi));
        check_eq("post_lo",    64'(lo),    64'(old_lo));
        hilo_rd = 1'b0;
    endtask

    // Starts a multiply, asserts reset in cycle 10 and checks the abort.
    task automatic reset_mid(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        op_a = a; op_b = b; signed_op = s; start = 1'b1; hilo_rd = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        check_eq("rst_pre_busy", 64'(busy), 64'(1));
        reset = 1'b1;
        #1;
        check_eq("rst_hi",    64'(hi),    64'(0));
        check_eq("rst_lo",    64'(lo),    64'(0));
        check_eq("rst_busy",  64'(busy),  64'(0));
        check_eq("rst_done",  64'(done),  64'(0));
        check_eq("rst_stall", 64'(stall), 64'(0));
        old_hi = '0;
        old_lo = '0;
        repeat (3) begin
            @(negedge clk);
            #1;
            check_eq("rst_hold_done", 64'(done), 64'(0));
        end
        reset = 1'b0;
        $display("reset abort a=%h b=%h signed=%0d hi=%h lo=%h", a, b, s, hi, lo);
        @(negedge clk);
        #1;
        check_eq("rst_post_busy", 64'(busy), 64'(0));
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rs;
        int           sel, rd;

        reset = 1'b1; start = 1'b0; signed_op = 1'b0; op_a = '0; op_b = '0; hilo_rd = 1'b0;
        old_hi = '0; old_lo = '0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("reset_hi",    64'(hi),    64'(0));
        check_eq("reset_lo",    64'(lo),    64'(0));
        check_eq("reset_busy",  64'(busy),  64'(0));
        check_eq("reset_stall", 64'(stall), 64'(0));
        check_eq("reset_done",  64'(done),  64'(0));
        reset = 1'b0;
        @(negedge clk);
        #1;

        // Directed corners
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 1'b1, 1'b0, '0, '0, 1'b0);
        run_op(32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 5, 1'b1, 1'b0, '0, '0, 1'b0);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 0, 1'b0, 1'b0, '0, '0, 1'b0);
        run_op(32'h0000_0007, 32'h0000_0010, 1'b0, 2, 1'b0, 1'b0, '0, '0, 1'b0);
        run_op(32'h1234_5678, 32'h0000_0000, 1'b0, 0, 1'b0, 1'b0, '0, '0, 1'b0);
        run_op(32'h0000_0005, 32'hFFFF_FFFF, 1'b1, 1, 1'b0, 1'b0, '0, '0, 1'b0);

        // Back-to-back: second request held on start throughout the first
        run_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 0, 1'b0, 1'b1,
               32'hDEAD_BEEF, 32'h0000_0123, 1'b0);
        run_op(32'hDEAD_BEEF, 32'h0000_0123, 1'b0, 0, 1'b0, 1'b0, '0, '0, 1'b0);

        // Abort by reset, then a normal operation
        reset_mid(32'h0000_FFFF, 32'h0000_FFFF, 1'b0);
        run_op(32'hFFFF_FFF0, 32'h0000_0003, 1'b1, 0, 1'b0, 1'b0, '0, '0, 1'b0);

        // Randomized operations
        for (int i = 0; i < 16; i++) begin
            ra  = $urandom;
            sel = $urandom_range(0, 3);
            case (sel)
                0:       rb = $urandom;
                1:       rb = W'($urandom_range(0, 255));
                2:       rb = W'($urandom_range(0, 1));
                default: rb = ($urandom_range(0, 1) == 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
            endcase
            rs = 1'($urandom);
            rd = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, W));
            run_op(ra, rb, rs, rd, 1'($urandom), 1'b0, '0, '0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
